// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line memory answering the pmem read/write/resp handshake
module pmem_responder #(
  parameter int LINE_BITS     = 256,
  parameter int ADDR_WIDTH    = 16,
  parameter int INDEX_BITS    = 11,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  protocol_error
);

  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam int LW  = ADDR_WIDTH - OFF;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [LW-1:0]          line_q, line_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [LINE_BITS-1:0]   rdata_q;
  logic [LINE_BITS-1:0]   mem_q [2**INDEX_BITS];

  logic [LW-1:0]          line_in;
  logic [7:0]             lat_m1;
  logic                   finish, acc_write, violation;
  logic [INDEX_BITS-1:0]  acc_idx;
  logic [LINE_BITS-1:0]   acc_wdata;
  logic                   unused_addr_bits;

  assign line_in          = pmem_address[ADDR_WIDTH-1:OFF];
  assign unused_addr_bits = ^pmem_address[OFF-1:0];
  assign lat_m1           = pmem_write ? 8'(WRITE_LATENCY - 1) : 8'(READ_LATENCY - 1);
  assign violation        = (write_q ? !pmem_write : (!pmem_read || pmem_write)) ||
                            (line_in != line_q) ||
                            (write_q && (pmem_wdata != wdata_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    line_d    = line_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    finish    = 1'b0;
    acc_write = write_q;
    acc_idx   = line_q[INDEX_BITS-1:0];
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          write_d = pmem_write;
          line_d  = line_in;
          wdata_d = pmem_wdata;
          cnt_d   = lat_m1;
          if (pmem_read && pmem_write) err_d = 1'b1;
          // Single-cycle latency completes on the accept edge straight from the inputs
          if (lat_m1 == 8'd0) begin
            state_d   = RESP;
            finish    = 1'b1;
            acc_write = pmem_write;
            acc_idx   = line_in[INDEX_BITS-1:0];
            acc_wdata = pmem_wdata;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (violation) err_d = 1'b1;
        if (cnt_d == 8'd0) begin
          state_d = RESP;
          finish  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      line_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (finish && !acc_write) rdata_q <= mem_q[acc_idx];
    end
  end

  // Array has no reset; reset only blocks a commit in the same cycle
  always_ff @(posedge clk) begin
    if (!reset && finish && acc_write) mem_q[acc_idx] <= acc_wdata;
  end

  assign pmem_rdata     = rdata_q;
  assign pmem_resp      = (state_q == RESP);
  assign protocol_error = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed bench with a cycle-indexed expectation model
module tb_pmem_responder;

  localparam int L = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         protocol_error;

  pmem_responder dut (
    .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;
  bit started = 0;

  // Expectations keyed by cycle number (cycle k follows rising edge k)
  bit           resp_at [int];
  logic [255:0] rdata_at [int];
  bit           err_set_at [int];
  logic [255:0] mem_m [int];
  logic [255:0] model_rdata = '0;
  logic         err_m = 1'b0;
  int           resp_log [$];
  logic [255:0] last_rdata = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        model_rdata = '0;
        err_m = 1'b0;
      end
      if (err_set_at.exists(cyc)) err_m = 1'b1;
      if (rdata_at.exists(cyc)) model_rdata = rdata_at[cyc];
      chk("resp", 256'(pmem_resp), 256'(resp_at.exists(cyc) && !rst_seen));
      chk("rdata", pmem_rdata, model_rdata);
      chk("protocol_error", 256'(protocol_error), 256'(err_m));
      if (pmem_resp) begin
        resp_log.push_back(cyc);
        last_rdata = pmem_rdata;
      end
    end
  end

  function automatic int idx_of(input logic [15:0] a);
    return int'((a >> 5) & 16'h07ff);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue a request in an IDLE cycle, hold it until the response cycle, then drop it
  task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                    input logic [255:0] d, output int acc);
    int rc;
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = d;
    acc = cyc + 1;
    rc = acc + L - 1;
    resp_at[rc] = 1;
    if (rd && wr) err_set_at[acc] = 1;
    if (!wr) rdata_at[rc] = mem_m[idx_of(a)];
    while (cyc < rc) tick();
    pmem_read = 0; pmem_write = 0;
    if (wr) mem_m[idx_of(a)] = d;
    tick();
  endtask

  logic [255:0] line_a, line_b, d1, d2, p_old, q_new, line_c;
  int acc, rc1, rc2, nlog;

  initial begin
    line_a = {4{64'h0123456789ABCDEF}};
    line_b = {4{64'hFEDCBA9876543210}};
    d1 = {8{32'h11110100}};
    d2 = {8{32'h22220200}};
    p_old = {16{16'hA5A5}};
    q_new = {16{16'h5A5A}};
    line_c = {8{32'hC0FFEE00}};
    tick(); tick();
    reset = 0;
    started = 1;
    chk("reset_resp", 256'(pmem_resp), 256'(0));
    chk("reset_err", 256'(protocol_error), 256'(0));
    chk("reset_rdata", pmem_rdata, 256'(0));

    op(0, 1, 16'h1A40, line_a, acc);
    chk("write_latency", 256'(resp_log[$] - acc), 256'(9));
    op(1, 0, 16'h1A40, '0, acc);
    chk("read_latency", 256'(resp_log[$] - acc), 256'(9));
    chk("read_line_a", last_rdata, line_a);

    op(0, 1, 16'h1A40, line_a, acc);
    op(0, 1, 16'h1A5F, line_b, acc);
    op(1, 0, 16'h1A40, '0, acc);
    chk("alias_read", last_rdata, line_b);

    // Held read: second accept in the IDLE cycle after RESP
    pmem_read = 1; pmem_address = 16'h1A40;
    acc = cyc + 1;
    rc1 = acc + L - 1;
    rc2 = rc1 + L + 1;
    resp_at[rc1] = 1; resp_at[rc2] = 1;
    rdata_at[rc1] = mem_m[idx_of(16'h1A40)];
    rdata_at[rc2] = mem_m[idx_of(16'h1A40)];
    while (cyc < rc2) tick();
    pmem_read = 0;
    tick();
    chk("held_spacing", 256'(resp_log[$] - resp_log[$-1]), 256'(11));
    chk("held_err", 256'(protocol_error), 256'(0));

    op(0, 1, 16'h0100, d1, acc);
    op(0, 1, 16'h0200, d2, acc);
    op(0, 1, 16'h2000, p_old, acc);

    // Address moves during the 3rd BUSY cycle of a read
    pmem_read = 1; pmem_address = 16'h0100;
    acc = cyc + 1;
    rc1 = acc + L - 1;
    resp_at[rc1] = 1;
    rdata_at[rc1] = mem_m[idx_of(16'h0100)];
    while (cyc < acc + 2) tick();
    pmem_address = 16'h0200;
    err_set_at[acc + 3] = 1;
    while (cyc < rc1) tick();
    pmem_read = 0;
    tick();
    chk("addr_change_data", last_rdata, d1);
    chk("addr_change_err", 256'(protocol_error), 256'(1));

    reset = 1; tick(); reset = 0; tick();
    chk("err_cleared", 256'(protocol_error), 256'(0));

    op(1, 1, 16'h0300, line_c, acc);
    chk("both_err", 256'(protocol_error), 256'(1));
    op(1, 0, 16'h0300, '0, acc);
    chk("both_wrote", last_rdata, line_c);
    chk("both_sticky", 256'(protocol_error), 256'(1));

    // Reset in the 5th BUSY cycle of a write aborts it
    nlog = resp_log.size();
    pmem_write = 1; pmem_address = 16'h2000; pmem_wdata = q_new;
    acc = cyc + 1;
    while (cyc < acc + 4) tick();
    reset = 1; pmem_write = 0;
    tick();
    reset = 0;
    op(1, 0, 16'h2000, '0, acc);
    chk("abort_no_resp", 256'(resp_log.size() - nlog), 256'(1));
    chk("abort_old_data", last_rdata, p_old);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable physical-memory responder: the slave end of the pmem read/write/resp handshake driven by the victim cache.
- Serves full-line reads and writes from an internal line-addressed array after a programmable fixed latency.
- Used as the memory behind the cache hierarchy in system simulation, and as a bring-up memory model on FPGA.
- Flags handshake violations by the initiator.

Parameters:
LINE_BITS, 256, width of one memory line (pmem_rdata/pmem_wdata); must be a power of two, at least 16
ADDR_WIDTH, 16, byte address width
INDEX_BITS, 11, log2 of array depth in lines; array covers 2^INDEX_BITS lines
READ_LATENCY, 10, cycles from request accept to pmem_resp for reads; range 1..255
WRITE_LATENCY, 10, cycles from request accept to pmem_resp for writes; range 1..255

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
pmem_read  in  1  read request; held by initiator until pmem_resp
pmem_write  in  1  write request; held by initiator until pmem_resp
pmem_address  in  ADDR_WIDTH  byte address; low log2(LINE_BITS/8) bits ignored (line-aligned)
pmem_wdata  in  LINE_BITS  write line data; held stable with pmem_write
pmem_rdata  out  LINE_BITS  read line data; valid in the pmem_resp cycle of a read
pmem_resp  out  1  one-cycle completion pulse
protocol_error  out  1  sticky flag, set on any handshake violation

Behaviour:
- Index: OFF = log2(LINE_BITS/8); idx = pmem_address[OFF+INDEX_BITS-1:OFF]; higher address bits ignored (aliasing).
- Array is not reset; contents X until written. Only control state is reset.
- Reset values: state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, protocol_error 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If pmem_read or pmem_write is high at the edge: latch op, idx and wdata; load counter with latency-1; enter BUSY, or RESP directly if latency = 1.
  - If both are high: treat as write and set protocol_error.
- BUSY: decrement counter each cycle; on the edge where counter = 0, enter RESP.
  - On that edge, a write commits the latched wdata to array[idx].
  - On that edge, a read loads pmem_rdata from array[idx].
- RESP: pmem_resp = 1 for exactly this one cycle; unconditionally return to IDLE next edge.
- Latency: a request accepted at edge N gives pmem_resp high in the cycle after edge N+L-1, i.e. L cycles after accept.
- pmem_rdata holds its value until the next read completes; writes do not change it.
- Back-to-back requests: the initiator may drop the request in the cycle after RESP. If it stays high in IDLE, it is accepted as a new request (no bubble other than the IDLE cycle).
- Minimum spacing between resp pulses is L+1 cycles.
- Violation checks while BUSY, against the latched request:
  - Request deasserted, op changed, or address line changed: set protocol_error.
  - For writes, wdata changed: set protocol_error.
  - Any violation: operation continues using the latched values.
- Write-to-read ordering: a read accepted after a write's resp returns the written data.
- Reset mid-operation: abort immediately to IDLE with pmem_resp 0 and no array update. A write already committed at an earlier edge stays committed.
- Reset has priority over all other events in the same cycle.

Test Plan:
- Reset, then write line 0x0123...EF at address 0x1A40 (latency 10) -> pmem_resp high exactly 10 cycles after accept, for 1 cycle; read of 0x1A40 returns the same line after 10 cycles.
- Write address 0x1A40 and 0x1A5F (same line, OFF=5) -> both hit idx 0xD2; a read of 0x1A40 returns the second write's data.
- Hold pmem_read high through RESP -> second resp exactly 11 cycles after the first; protocol_error stays 0.
- Assert pmem_read and pmem_write together -> write performed, protocol_error = 1 and sticky until reset.
- Change pmem_address from 0x0100 to 0x0200 in the 3rd BUSY cycle of a read -> data returned from 0x0100, protocol_error = 1.
- Assert reset in the 5th BUSY cycle of a write to 0x2000 -> no resp, back in IDLE next cycle; a later read of 0x2000 returns the previous contents.
